hms_time_counter: RTL and testbench

Time-of-day engine for the clock design. It divides the system clock into a one-second tick and keeps hours, minutes and seconds as packed BCD. It accepts a validated time load and minute/hour set buttons. Its packed BCD output feeds the 7-segment display scanner directly downstream.

---
 rtl/clock_pkg.sv | 22 ++
 rtl/bcd_digit_counter.sv | 44 ++++
 rtl/hms_time_counter.sv | 134 +++++++++++++
 tb/tb_hms_time_counter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared types and limits for the time-of-day engine.
//   bcd_digit_t  one packed BCD digit (4 bits)
//   hms_t        {h10,h1,m10,m1,s10,s1}, 24 bits, same packing as bcd_time
//   *_MAX        upper limits of the seconds/minutes digits
package clock_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef struct packed {
      bcd_digit_t h10;
      bcd_digit_t h1;
      bcd_digit_t m10;
      bcd_digit_t m1;
      bcd_digit_t s10;
      bcd_digit_t s1;
   } hms_t;

   localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
   localparam bcd_digit_t MIN_TENS_MAX = 4'd5;
   localparam bcd_digit_t DIGIT_MAX    = 4'd9;

endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: one BCD digit counting 0..MAX with wrap.
//   clock, reset  system clock, asynchronous active-low reset
//   inc           advance by one this cycle
//   load          overwrite with load_val (wins over inc)
//   value         registered digit
//   carry         combinational: inc while value==MAX, i.e. this digit wraps
module bcd_digit_counter
   import clock_pkg::*;
#(
   parameter bcd_digit_t MAX = DIGIT_MAX
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       inc,
   input  logic       load,
   input  bcd_digit_t load_val,
   output bcd_digit_t value,
   output logic       carry
);

   bcd_digit_t value_d, value_q;

   assign carry = inc && (value_q == MAX);

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (inc) begin
         value_d = carry ? '0 : value_q + 4'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/hms_time_counter.sv
// hms_time_counter: time-of-day engine, packed BCD hours/minutes/seconds.
//   clock, reset   system clock, asynchronous active-low reset
//   run            1 = prescaler counts, 0 = prescaler and time frozen
//   set_valid/set_hms/set_ready  time load handshake
//   set_err        one-cycle pulse: accepted load was invalid and discarded
//   inc_min        minutes +1 (no hour carry)
//   inc_hour       hours +1 with wrap
//   bcd_time       current time {h10,h1,m10,m1,s10,s1}
//   sec_pulse      one-cycle pulse when bcd_time advanced because of a tick
module hms_time_counter
   import clock_pkg::*;
#(
   parameter int unsigned TICK_DIV = 65536,
   parameter int unsigned HOUR_MAX = 23
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   input  logic        set_valid,
   input  logic [23:0] set_hms,
   output logic        set_ready,
   output logic        set_err,
   input  logic        inc_min,
   input  logic        inc_hour,
   output logic [23:0] bcd_time,
   output logic        sec_pulse
);

   localparam int unsigned     PreW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PreW-1:0] PreLast  = PreW'(TICK_DIV - 1);
   localparam bcd_digit_t      HourTens = bcd_digit_t'(HOUR_MAX / 10);
   localparam bcd_digit_t      HourOnes = bcd_digit_t'(HOUR_MAX % 10);

   hms_t            req;
   logic            hours_gt, req_ok, accept, load_ok, load_bad;
   logic            tick, tick_en, min_en, hour_en, hour_inc;
   logic [PreW-1:0] pre_d, pre_q;
   logic            set_ready_q, set_err_q, sec_pulse_q;
   bcd_digit_t      s1, s10, m1, m10;
   logic            s1_carry, s10_carry, m1_carry, m10_carry;
   bcd_digit_t      h10_d, h10_q, h1_d, h1_q;

   // Load validation
   assign req      = set_hms;
   assign hours_gt = (req.h10 > HourTens) || ((req.h10 == HourTens) && (req.h1 > HourOnes));
   assign req_ok   = (req.s1 <= DIGIT_MAX) && (req.m1 <= DIGIT_MAX) &&
                     (req.h1 <= DIGIT_MAX) && (req.h10 <= DIGIT_MAX) &&
                     (req.s10 <= SEC_TENS_MAX) && (req.m10 <= MIN_TENS_MAX) && !hours_gt;
   assign accept   = set_valid && set_ready_q;
   assign load_ok  = accept && req_ok;
   assign load_bad = accept && !req_ok;

   // A valid load suppresses every advance in its cycle; an invalid one does not.
   assign tick    = run && (pre_q == PreLast);
   assign tick_en = tick && !load_ok;
   assign min_en  = inc_min && !load_ok;
   assign hour_en = inc_hour && !load_ok;

   always_comb begin
      pre_d = pre_q;
      if (load_ok) begin
         pre_d = '0;
      end else if (run) begin
         pre_d = (pre_q == PreLast) ? '0 : pre_q + PreW'(1);
      end
   end

   bcd_digit_counter #(.MAX(DIGIT_MAX)) u_s1 (
      .clock(clock), .reset(reset), .inc(tick_en), .load(load_ok), .load_val(req.s1),
      .value(s1), .carry(s1_carry)
   );

   bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_s10 (
      .clock(clock), .reset(reset), .inc(s1_carry), .load(load_ok), .load_val(req.s10),
      .value(s10), .carry(s10_carry)
   );

   // inc_min and the seconds carry merge into a single minute advance.
   bcd_digit_counter #(.MAX(DIGIT_MAX)) u_m1 (
      .clock(clock), .reset(reset), .inc(min_en || s10_carry), .load(load_ok),
      .load_val(req.m1), .value(m1), .carry(m1_carry)
   );

   bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_m10 (
      .clock(clock), .reset(reset), .inc(m1_carry), .load(load_ok), .load_val(req.m10),
      .value(m10), .carry(m10_carry)
   );

   // Minute wrap reaches the hours only when the advance came from the seconds.
   assign hour_inc = hour_en || (m10_carry && s10_carry);

   always_comb begin
      h10_d = h10_q;
      h1_d  = h1_q;
      if (load_ok) begin
         h10_d = req.h10;
         h1_d  = req.h1;
      end else if (hour_inc) begin
         if ((h10_q == HourTens) && (h1_q == HourOnes)) begin
            h10_d = '0;
            h1_d  = '0;
         end else if (h1_q == DIGIT_MAX) begin
            h10_d = h10_q + 4'd1;
            h1_d  = '0;
         end else begin
            h1_d = h1_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pre_q       <= '0;
         h10_q       <= '0;
         h1_q        <= '0;
         set_ready_q <= 1'b0;
         set_err_q   <= 1'b0;
         sec_pulse_q <= 1'b0;
      end else begin
         pre_q       <= pre_d;
         h10_q       <= h10_d;
         h1_q        <= h1_d;
         set_ready_q <= 1'b1;
         set_err_q   <= load_bad;
         sec_pulse_q <= tick_en;
      end
   end

   assign set_ready = set_ready_q;
   assign set_err   = set_err_q;
   assign sec_pulse = sec_pulse_q;
   assign bcd_time  = {h10_q, h1_q, m10, m1, s10, s1};

endmodule

// File: tb/tb_hms_time_counter.sv
// tb_hms_time_counter: randomized and directed checks of hms_time_counter
// against an arithmetic time-of-day model (hours/minutes/seconds as integers).
module tb_hms_time_counter;

   localparam int TICK_DIV = 4;
   localparam int HOUR_MAX = 23;

   logic        clock     = 1'b0;
   logic        reset     = 1'b1;
   logic        run       = 1'b0;
   logic        set_valid = 1'b0;
   logic [23:0] set_hms   = '0;
   logic        inc_min   = 1'b0;
   logic        inc_hour  = 1'b0;
   logic        set_ready, set_err, sec_pulse;
   logic [23:0] bcd_time;

   int tests = 0;
   int fails = 0;

   // Model state: plain integers for the time, prescaler count and flags
   int m_h, m_m, m_s, m_pre;
   bit m_ready, m_err, m_pulse;

   always #5 clock = ~clock;

   hms_time_counter #(.TICK_DIV(TICK_DIV), .HOUR_MAX(HOUR_MAX)) dut (
      .clock(clock), .reset(reset), .run(run), .set_valid(set_valid), .set_hms(set_hms),
      .set_ready(set_ready), .set_err(set_err), .inc_min(inc_min), .inc_hour(inc_hour),
      .bcd_time(bcd_time), .sec_pulse(sec_pulse)
   );

   function automatic logic [23:0] to_bcd(input int h, input int m, input int s);
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic bit hms_valid(input logic [23:0] v);
      for (int i = 0; i < 6; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
      if (v[7:4] > 4'd5 || v[15:12] > 4'd5) return 1'b0;
      return (int'(v[23:20]) * 10 + int'(v[19:16])) <= HOUR_MAX;
   endfunction

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_h = 0; m_m = 0; m_s = 0; m_pre = 0;
      m_ready = 0; m_err = 0; m_pulse = 0;
   endtask

   task automatic model_step();
      bit acc, good, tick, sc, madv, mc;
      acc  = set_valid && m_ready;
      good = acc && hms_valid(set_hms);
      tick = run && (m_pre == TICK_DIV - 1);
      m_err   = acc && !good;
      m_ready = 1'b1;
      if (good) begin
         m_h = int'(set_hms[23:20]) * 10 + int'(set_hms[19:16]);
         m_m = int'(set_hms[15:12]) * 10 + int'(set_hms[11:8]);
         m_s = int'(set_hms[7:4]) * 10 + int'(set_hms[3:0]);
         m_pre   = 0;
         m_pulse = 1'b0;
      end else begin
         if (run) m_pre = (m_pre + 1) % TICK_DIV;
         sc = tick && (m_s == 59);
         if (tick) m_s = (m_s + 1) % 60;
         madv = inc_min || sc;
         mc   = madv && sc && (m_m == 59);
         if (madv) m_m = (m_m + 1) % 60;
         if (inc_hour || mc) m_h = (m_h + 1) % (HOUR_MAX + 1);
         m_pulse = tick;
      end
   endtask

   // Compare process: advance the model on every active edge, check just after it.
   initial begin
      forever begin
         @(posedge clock);
         if (reset) begin
            model_step();
            #1;
            check("time", bcd_time, to_bcd(m_h, m_m, m_s));
            check("sec_pulse", sec_pulse, m_pulse);
            check("set_err", set_err, m_err);
            check("set_ready", set_ready, m_ready);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic load(input logic [23:0] v);
      set_valid = 1'b1;
      set_hms   = v;
      cyc(1);
      set_valid = 1'b0;
   endtask

   initial begin
      model_reset();
      #1 reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_time", bcd_time, 24'h000000);
      check("rst_pulse", sec_pulse, 1'b0);
      check("rst_err", set_err, 1'b0);
      check("rst_ready", set_ready, 1'b0);

      // Release and count to the first tick, then to one minute
      @(posedge clock);
      #2;
      reset = 1'b1;
      run   = 1'b1;
      cyc(3);
      check("first_tick_early", sec_pulse, 1'b0);
      cyc(1);
      check("first_tick_pulse", sec_pulse, 1'b1);
      check("first_tick_time", bcd_time, 24'h000001);
      cyc(59 * TICK_DIV);
      check("one_minute", bcd_time, 24'h000100);

      // Full-day wrap
      load(24'h235959);
      check("load_235959", bcd_time, 24'h235959);
      cyc(TICK_DIV);
      check("day_wrap_time", bcd_time, 24'h000000);
      check("day_wrap_pulse", sec_pulse, 1'b1);

      // Invalid load is discarded
      load(24'h101010);
      set_valid = 1'b1;
      set_hms   = 24'h246000;
      cyc(1);
      set_valid = 1'b0;
      check("bad_load_err", set_err, 1'b1);
      check("bad_load_time", bcd_time, 24'h101010);
      cyc(1);
      check("bad_load_err_clear", set_err, 1'b0);

      // Manual minute / hour buttons
      load(24'h125930);
      inc_min = 1'b1;
      cyc(1);
      inc_min = 1'b0;
      check("inc_min_no_carry", bcd_time, 24'h120030);
      load(24'h230000);
      inc_hour = 1'b1;
      cyc(1);
      inc_hour = 1'b0;
      check("inc_hour_wrap", bcd_time, 24'h000000);

      // Tick carry and inc_min in the same cycle give one minute step
      load(24'h103059);
      cyc(TICK_DIV - 1);
      inc_min = 1'b1;
      cyc(1);
      inc_min = 1'b0;
      check("merged_min_time", bcd_time, 24'h103100);
      check("merged_min_pulse", sec_pulse, 1'b1);

      // Frozen while run=0, load still applies, restart counts from zero
      run = 1'b0;
      cyc(10);
      check("frozen_time", bcd_time, 24'h103100);
      check("frozen_pulse", sec_pulse, 1'b0);
      load(24'h080000);
      check("stopped_load", bcd_time, 24'h080000);
      run = 1'b1;
      cyc(TICK_DIV - 1);
      check("restart_early", sec_pulse, 1'b0);
      cyc(1);
      check("restart_pulse", sec_pulse, 1'b1);
      check("restart_time", bcd_time, 24'h080001);

      // Randomized traffic with occasional asynchronous resets
      for (int i = 0; i < 4000; i++) begin
         if (i % 1000 == 700) begin
            reset     = 1'b0;
            set_valid = 1'b0;
            inc_min   = 1'b0;
            inc_hour  = 1'b0;
            model_reset();
            #1;
            check("async_rst_time", bcd_time, 24'h000000);
            check("async_rst_ready", set_ready, 1'b0);
            @(posedge clock);
            #2;
            reset = 1'b1;
         end
         run       = ($urandom_range(0, 9) != 0);
         inc_min   = ($urandom_range(0, 19) == 0);
         inc_hour  = ($urandom_range(0, 29) == 0);
         set_valid = ($urandom_range(0, 24) == 0);
         case ($urandom_range(0, 3))
            0: set_hms = 24'($urandom);
            1: set_hms = to_bcd(HOUR_MAX, 59, $urandom_range(55, 59));
            default: set_hms = to_bcd($urandom_range(0, HOUR_MAX), $urandom_range(0, 59),
                                      $urandom_range(0, 59));
         endcase
         cyc(1);
      end
      set_valid = 1'b0;
      inc_min   = 1'b0;
      inc_hour  = 1'b0;
      cyc(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
